// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer. One shared 1-bit add cell handles one
// operand bit per clock, LSB first, and reports result, carry/borrow and overflow.
//
// Ports:
//   clk, rst  : clock, async active-high reset
//   start     : request pulse, only sampled in IDLE
//   op        : 0 = a+b, 1 = a-b (sampled with start)
//   a, b      : WIDTH-bit operands (sampled with start)
//   busy      : high while the add cell is stepping (RUN)
//   done      : one-cycle pulse when result/carry_out/overflow are valid
//   result    : sum or difference, held until the next accepted start
//   carry_out : add carry, or subtract borrow (inverted final carry)
//   overflow  : signed overflow

module serial_add_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic h1;
  logic g1;
  logic g2;

  // two half adders plus an OR form the full adder
  always_comb begin
    h1 = x ^ y;
    g1 = x & y;
    s  = h1 ^ ci;
    g2 = h1 & ci;
    co = g1 | g2;
  end

endmodule

module serial_addsub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sa_d;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] sb_d;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             c_q;
  logic             c_d;
  logic             op_q;
  logic             op_d;
  logic             carry_out_q;
  logic             carry_out_d;
  logic             overflow_q;
  logic             overflow_d;

  logic             bit_s;
  logic             bit_c;

  serial_add_cell u_cell (
    .x  (sa_q[0]),
    .y  (sb_q[0]),
    .ci (c_q),
    .s  (bit_s),
    .co (bit_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sa_q        <= '0;
      sb_q        <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      c_q         <= 1'b0;
      op_q        <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      result_q    <= result_d;
      cnt_q       <= cnt_d;
      c_q         <= c_d;
      op_q        <= op_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    result_d    = result_q;
    cnt_d       = cnt_q;
    c_d         = c_q;
    op_d        = op_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sa_d     = a;
          // subtract = a + ~b + 1; the +1 rides in as carry-in
          sb_d     = op ? ~b : b;
          c_d      = op;
          op_d     = op;
          cnt_d    = '0;
          result_d = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        result_d = {bit_s, result_q[WIDTH-1:1]};
        sa_d     = {1'b0, sa_q[WIDTH-1:1]};
        sb_d     = {1'b0, sb_q[WIDTH-1:1]};
        c_d      = bit_c;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // c_q is the carry into the MSB on this last step
          carry_out_d = bit_c ^ op_q;
          overflow_d  = c_q ^ bit_c;
          cnt_d       = '0;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Testbench for serial_addsub_ctrl: WIDTH=8 and WIDTH=4 instances,
// table vectors, random ops, back-to-back, async abort.

module tb_serial_addsub_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0;
  logic       op8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       busy8;
  logic       done8;
  logic [7:0] result8;
  logic       co8;
  logic       ov8;

  logic       start4 = 1'b0;
  logic       op4 = 1'b0;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       busy4;
  logic       done4;
  logic [3:0] result4;
  logic       co4;
  logic       ov4;

  int ntot = 0;
  int nbad = 0;

  typedef struct {
    logic [7:0] r;
    logic       co;
    logic       ov;
  } exp_t;

  typedef struct {
    logic       sel4;
    logic       op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic       co;
    logic       ov;
  } vec_t;

  exp_t q8[$];
  exp_t q4[$];
  vec_t tv[12];

  always #5 clk = ~clk;

  serial_addsub_ctrl #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .start     (start8),
    .op        (op8),
    .a         (a8),
    .b         (b8),
    .busy      (busy8),
    .done      (done8),
    .result    (result8),
    .carry_out (co8),
    .overflow  (ov8)
  );

  serial_addsub_ctrl #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .start     (start4),
    .op        (op4),
    .a         (a4),
    .b         (b4),
    .busy      (busy4),
    .done      (done4),
    .result    (result4),
    .carry_out (co4),
    .overflow  (ov4)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ntot++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // integer reference model for 8-bit ops: {r, co, ov}
  function automatic logic [9:0] model(input logic op, input logic [7:0] a,
                                       input logic [7:0] b);
    logic [8:0] w;
    logic       ov;
    if (op) begin
      w  = {1'b0, a} - {1'b0, b};
      ov = (a[7] ^ b[7]) & (w[7] ^ a[7]);
    end else begin
      w  = {1'b0, a} + {1'b0, b};
      ov = ~(a[7] ^ b[7]) & (w[7] ^ a[7]);
    end
    return {w[7:0], w[8], ov};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (done8) begin
      if (q8.size() == 0) begin
        chk("unexpected_done8", 32'd1, 32'd0);
      end else begin
        e = q8.pop_front();
        chk("result8", {24'd0, result8}, {24'd0, e.r});
        chk("carry8", {31'd0, co8}, {31'd0, e.co});
        chk("ovf8", {31'd0, ov8}, {31'd0, e.ov});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done4) begin
      if (q4.size() == 0) begin
        chk("unexpected_done4", 32'd1, 32'd0);
      end else begin
        e = q4.pop_front();
        chk("result4", {28'd0, result4}, {28'd0, e.r[3:0]});
        chk("carry4", {31'd0, co4}, {31'd0, e.co});
        chk("ovf4", {31'd0, ov4}, {31'd0, e.ov});
      end
    end
  end

  // one op from idle; checks busy window, single done pulse,
  // and scrambles inputs mid-run
  task automatic do_op(input logic sel4, input logic op,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] r, input logic co,
                       input logic ov);
    exp_t e;
    int   w;
    int   nb;
    w  = sel4 ? 4 : 8;
    nb = 0;
    e.r  = r;
    e.co = co;
    e.ov = ov;
    @(negedge clk);
    if (sel4) begin
      start4 = 1'b1;
      op4    = op;
      a4     = a[3:0];
      b4     = b[3:0];
      q4.push_back(e);
    end else begin
      start8 = 1'b1;
      op8    = op;
      a8     = a;
      b8     = b;
      q8.push_back(e);
    end
    for (int k = 0; k < w; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start4 = 1'b0;
        start8 = 1'b0;
      end
      op4 = 1'($urandom);
      a4  = 4'($urandom);
      b4  = 4'($urandom);
      op8 = 1'($urandom);
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      if (sel4 ? (busy4 && !done4) : (busy8 && !done8))
        nb++;
    end
    chk("busy_window", nb, w);
    @(negedge clk);
    chk("done_pulse", sel4 ? {done4, busy4} : {done8, busy8}, 2'b10);
    @(negedge clk);
    chk("done_one_cycle", sel4 ? done4 : done8, 1'b0);
  endtask

  initial begin
    logic [9:0] m;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       ro;
    int         t;
    int         nd;
    int         dt[3];
    bit         seen;

    tv[0]  = '{0, 0, 8'd100, 8'd27,  8'd127, 0, 0};
    tv[1]  = '{0, 0, 8'd200, 8'd100, 8'h2C,  1, 0};
    tv[2]  = '{0, 0, 8'd127, 8'd1,   8'h80,  0, 1};
    tv[3]  = '{0, 1, 8'd5,   8'd7,   8'hFE,  1, 0};
    tv[4]  = '{0, 1, 8'h80,  8'd1,   8'h7F,  0, 1};
    tv[5]  = '{0, 0, 8'd0,   8'd0,   8'h00,  0, 0};
    tv[6]  = '{0, 1, 8'h55,  8'h55,  8'h00,  0, 0};
    tv[7]  = '{0, 0, 8'hFF,  8'hFF,  8'hFE,  1, 0};
    tv[8]  = '{1, 0, 8'd7,   8'd9,   8'h00,  1, 0};
    tv[9]  = '{1, 1, 8'd3,   8'd3,   8'h00,  0, 0};
    tv[10] = '{1, 0, 8'd5,   8'd6,   8'h0B,  0, 1};
    tv[11] = '{1, 1, 8'd2,   8'd5,   8'h0D,  1, 0};

    repeat (2) @(negedge clk);
    chk("rst_outs8", {busy8, done8, result8, co8, ov8}, 0);
    chk("rst_outs4", {busy4, done4, result4, co4, ov4}, 0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++)
      do_op(tv[i].sel4, tv[i].op, tv[i].a, tv[i].b,
            tv[i].r, tv[i].co, tv[i].ov);

    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      ro = 1'($urandom);
      m  = model(ro, ra, rb);
      do_op(1'b0, ro, ra, rb, m[9:2], m[1], m[0]);
    end

    // start held high: one op every WIDTH+2 cycles
    m = model(1'b0, 8'h12, 8'h34);
    for (int i = 0; i < 3; i++)
      q8.push_back('{m[9:2], m[1], m[0]});
    @(negedge clk);
    start8 = 1'b1;
    op8    = 1'b0;
    a8     = 8'h12;
    b8     = 8'h34;
    nd     = 0;
    t      = 0;
    while (nd < 3 && t < 60) begin
      @(negedge clk);
      t++;
      if (done8) begin
        dt[nd] = t;
        nd++;
      end
    end
    start8 = 1'b0;
    chk("b2b_count", nd, 3);
    if (nd == 3) begin
      chk("b2b_gap1", dt[1] - dt[0], 10);
      chk("b2b_gap2", dt[2] - dt[1], 10);
    end
    @(negedge clk);

    // leave carry_out/overflow set so the abort clear is visible
    do_op(1'b0, 1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1);

    @(negedge clk);
    start8 = 1'b1;
    op8    = 1'b0;
    a8     = 8'h33;
    b8     = 8'h11;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_outs", {busy8, done8, result8, co8, ov8}, 0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done8)
        seen = 1'b1;
    end
    chk("abort_no_done", seen, 1'b0);

    do_op(1'b0, 1'b0, 8'd1, 8'd1, 8'd2, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    chk("q8_empty", q8.size(), 0);
    chk("q4_empty", q4.size(), 0);

    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end

endmodule
